// File: rtl/core_pkg.sv
// Shared core constants: RV32 load/store funct3 codes, LSU FSM states and
// the lane-alignment helpers used by the load/store unit.
package core_pkg;

  localparam int CORE_XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_t;

  // Byte offset after clearing the low bits the access width does not allow.
  function automatic logic [1:0] align_offset(input logic [2:0] funct3, input logic [1:0] a);
    logic [1:0] off;
    case (funct3[1:0])
      2'b00:   off = a;
      2'b01:   off = {a[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane select and zero/sign extension for RV32 loads.
module load_align
  import core_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      a,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte/halfword, then extend according to funct3.
  always_comb begin
    case (a)
      2'b00:   lane_b = rdata[7:0];
      2'b01:   lane_b = rdata[15:8];
      2'b10:   lane_b = rdata[23:16];
      2'b11:   lane_b = rdata[31:24];
      default: lane_b = rdata[7:0];
    endcase
    if (a[1]) begin
      lane_h = rdata[31:16];
    end else begin
      lane_h = rdata[15:0];
    end
    case (funct3)
      F3_LB:   data = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, lane_b};
      F3_LH:   data = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit: single outstanding data-memory access, one-cycle
// retire for non-memory ops. Optional macro LSU_MISALIGN_TRAP_EN traps
// misaligned accesses instead of force-aligning them.
module load_store_unit
  import core_pkg::*;
#(
  parameter int XLEN = CORE_XLEN,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_mem_rd,
  input  logic            ex_mem_wr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_rf_we,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [REGW-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_exc
);

  lsu_state_t      state, state_next;
  logic            is_mem;
  logic            misaligned;
  logic [1:0]      off;
  logic [3:0]      be;
  logic [XLEN-1:0] store_data;
  logic [1:0]      req_off;
  logic [2:0]      req_funct3;
  logic [REGW-1:0] req_rd;
  logic            req_rf_we;
  logic [XLEN-1:0] load_data;

  assign ex_ready = (state == ST_IDLE);

  // Decode the presented op: alignment, byte enables and lane-replicated data.
  always_comb begin
    is_mem = ex_mem_rd | ex_mem_wr;
    off    = align_offset(ex_funct3, ex_addr[1:0]);
    be     = byte_enables(ex_funct3, off);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = (off != ex_addr[1:0]);
`else
    misaligned = 1'b0;
`endif
    case (ex_funct3[1:0])
      2'b00:   store_data = {4{ex_wdata[7:0]}};
      2'b01:   store_data = {2{ex_wdata[15:0]}};
      default: store_data = ex_wdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (ex_valid && is_mem && !misaligned) begin
          state_next = ST_REQ;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          state_next = dmem_we ? ST_IDLE : ST_WAIT;
        end else begin
          state_next = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WAIT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (dmem_rdata),
    .a      (req_off),
    .funct3 (req_funct3),
    .data   (load_data)
  );

  // Request/writeback registers; wb_valid and wb_exc are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= {XLEN{1'b0}};
      dmem_be    <= 4'b0000;
      dmem_wdata <= {XLEN{1'b0}};
      req_off    <= 2'b00;
      req_funct3 <= 3'b000;
      req_rd     <= {REGW{1'b0}};
      req_rf_we  <= 1'b0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= {REGW{1'b0}};
      wb_data    <= {XLEN{1'b0}};
      wb_exc     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_exc   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ex_valid && !is_mem) begin
            wb_valid <= 1'b1;
            wb_we    <= ex_rf_we;
            wb_rd    <= ex_rd;
            wb_data  <= ex_addr;
          end else if (ex_valid && misaligned) begin
            wb_valid <= 1'b1;
            wb_we    <= 1'b0;
            wb_rd    <= ex_rd;
            wb_exc   <= 1'b1;
          end else if (ex_valid) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ex_mem_wr;
            dmem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
            dmem_be    <= be;
            dmem_wdata <= store_data;
            req_off    <= off;
            req_funct3 <= ex_funct3;
            req_rd     <= ex_rd;
            req_rf_we  <= ex_rf_we;
          end
        end
        ST_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_rd    <= req_rd;
            end
          end
        end
        ST_WAIT: begin
          if (dmem_rvalid) begin
            wb_valid <= 1'b1;
            wb_we    <= req_rf_we;
            wb_rd    <= req_rd;
            wb_data  <= load_data;
          end
        end
        default: begin
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; expectations for the
// misaligned LW follow whether LSU_MISALIGN_TRAP_EN is defined.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_mem_rd, ex_mem_wr, ex_rf_we;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_we, wb_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .ex_rf_we(ex_rf_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_rf_we = 1'b0;
    ex_funct3 = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int gnt_wait,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata);
    ex_valid = 1'b1; ex_mem_wr = 1'b1; ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata;
    ex_rd = 5'd0; ex_rf_we = 1'b0;
    tick();
    ex_valid = 1'b0; ex_mem_wr = 1'b0;
    for (int i = 0; i <= gnt_wait; i++) begin
      check({tag, "_req"},   {31'd0, dmem_req}, 32'd1);
      check({tag, "_we"},    {31'd0, dmem_we},  32'd1);
      check({tag, "_addr"},  dmem_addr, exp_addr);
      check({tag, "_be"},    {28'd0, dmem_be}, {28'd0, exp_be});
      check({tag, "_wdata"}, dmem_wdata, exp_wdata);
      check({tag, "_ready"}, {31'd0, ex_ready}, 32'd0);
      dmem_gnt = (i == gnt_wait);
      tick();
    end
    dmem_gnt = 1'b0;
    check({tag, "_wbv"},    {31'd0, wb_valid}, 32'd1);
    check({tag, "_wbwe"},   {31'd0, wb_we},    32'd0);
    check({tag, "_reqoff"}, {31'd0, dmem_req}, 32'd0);
    tick();
    check({tag, "_wbv_end"}, {31'd0, wb_valid}, 32'd0);
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input int gnt_wait, input int rv_wait,
                          input logic [31:0] exp_addr, input logic [31:0] exp_data);
    int pulses;
    int ready_hi;
    pulses = 0;
    ready_hi = 0;
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_funct3 = f3; ex_addr = addr;
    ex_rd = 5'd7; ex_rf_we = 1'b1;
    tick();
    ex_valid = 1'b0; ex_mem_rd = 1'b0;
    check({tag, "_req"},  {31'd0, dmem_req}, 32'd1);
    check({tag, "_we"},   {31'd0, dmem_we},  32'd0);
    check({tag, "_addr"}, dmem_addr, exp_addr);
    for (int i = 0; i <= gnt_wait; i++) begin
      ready_hi += int'(ex_ready);
      dmem_gnt = (i == gnt_wait);
      dmem_rvalid = (i != gnt_wait);
      dmem_rdata = 32'hDEAD_BEEF;
      tick();
      pulses += int'(wb_valid);
    end
    dmem_gnt = 1'b0;
    for (int j = 0; j <= rv_wait; j++) begin
      ready_hi += int'(ex_ready);
      dmem_rvalid = (j == rv_wait);
      dmem_rdata = (j == rv_wait) ? rdata : 32'h5555_AAAA;
      tick();
      pulses += int'(wb_valid);
    end
    dmem_rvalid = 1'b0;
    check({tag, "_data"},  wb_data, exp_data);
    check({tag, "_wbwe"},  {31'd0, wb_we},  32'd1);
    check({tag, "_wbrd"},  {27'd0, wb_rd},  32'd7);
    check({tag, "_exc"},   {31'd0, wb_exc}, 32'd0);
    tick();
    pulses += int'(wb_valid);
    check({tag, "_pulses"}, pulses, 32'd1);
    check({tag, "_busy_ready"}, ready_hi, 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("rst_ready", {31'd0, ex_ready}, 32'd1);
    check("rst_req",   {31'd0, dmem_req}, 32'd0);
    check("rst_wbv",   {31'd0, wb_valid}, 32'd0);
    check("rst_exc",   {31'd0, wb_exc},   32'd0);
    check("rst_data",  wb_data, 32'd0);
    rst = 1'b0;

    // Back-to-back non-memory ops retire one per cycle.
    ex_valid = 1'b1; ex_addr = 32'h0000_1234; ex_rd = 5'd5; ex_rf_we = 1'b1;
    tick();
    check("alu_wbv",   {31'd0, wb_valid}, 32'd1);
    check("alu_data",  wb_data, 32'h0000_1234);
    check("alu_rd",    {27'd0, wb_rd}, 32'd5);
    check("alu_we",    {31'd0, wb_we}, 32'd1);
    check("alu_ready", {31'd0, ex_ready}, 32'd1);
    ex_addr = 32'h0000_5678; ex_rd = 5'd6;
    tick();
    check("alu2_wbv",  {31'd0, wb_valid}, 32'd1);
    check("alu2_data", wb_data, 32'h0000_5678);
    ex_valid = 1'b0;
    tick();
    check("alu_idle_wbv",  {31'd0, wb_valid}, 32'd0);
    check("alu_hold_data", wb_data, 32'h0000_5678);
    check("alu_hold_rd",   {27'd0, wb_rd}, 32'd6);

    run_store("sb",  3'b000, 32'h0000_0103, 32'h0000_00AB, 2,
              32'h0000_0100, 4'b1000, 32'hABAB_ABAB);
    run_store("sh",  3'b001, 32'h0000_0102, 32'h0000_C0DE, 1,
              32'h0000_0100, 4'b1100, 32'hC0DE_C0DE);
    run_store("sw",  3'b010, 32'h0000_0104, 32'h1122_3344, 0,
              32'h0000_0104, 4'b1111, 32'h1122_3344);

    run_load("lb",  3'b000, 32'h0000_0201, 32'h0000_80FF, 0, 0, 32'h0000_0200, 32'hFFFF_FF80);
    run_load("lbu", 3'b100, 32'h0000_0201, 32'h0000_80FF, 0, 0, 32'h0000_0200, 32'h0000_0080);
    run_load("lhu", 3'b101, 32'h0000_0202, 32'hBEEF_0000, 1, 1, 32'h0000_0200, 32'h0000_BEEF);
    run_load("lh",  3'b001, 32'h0000_0200, 32'h0000_8001, 0, 1, 32'h0000_0200, 32'hFFFF_8001);
    run_load("lw",  3'b010, 32'h0000_0400, 32'h1234_5678, 3, 2, 32'h0000_0400, 32'h1234_5678);

    // Reset while waiting for load data; the late rvalid must be dropped.
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h0000_0500;
    ex_rd = 5'd9; ex_rf_we = 1'b1;
    tick();
    ex_valid = 1'b0; ex_mem_rd = 1'b0; dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check("rstw_ready_wait", {31'd0, ex_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_ready", {31'd0, ex_ready}, 32'd1);
    check("rstw_wbv",   {31'd0, wb_valid}, 32'd0);
    check("rstw_req",   {31'd0, dmem_req}, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
    tick();
    dmem_rvalid = 1'b0;
    check("rstw_stale_wbv",   {31'd0, wb_valid}, 32'd0);
    check("rstw_stale_ready", {31'd0, ex_ready}, 32'd1);

`ifdef LSU_MISALIGN_TRAP_EN
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h0000_0302;
    ex_rd = 5'd3; ex_rf_we = 1'b1;
    tick();
    ex_valid = 1'b0; ex_mem_rd = 1'b0;
    check("mis_req",   {31'd0, dmem_req}, 32'd0);
    check("mis_wbv",   {31'd0, wb_valid}, 32'd1);
    check("mis_exc",   {31'd0, wb_exc},   32'd1);
    check("mis_we",    {31'd0, wb_we},    32'd0);
    check("mis_ready", {31'd0, ex_ready}, 32'd1);
    tick();
    check("mis_exc_end", {31'd0, wb_exc},   32'd0);
    check("mis_req_end", {31'd0, dmem_req}, 32'd0);
`else
    run_load("lw_mis", 3'b010, 32'h0000_0302, 32'hCAFE_F00D, 0, 0, 32'h0000_0300, 32'hCAFE_F00D);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
